// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the divider configuration stage.
package clk_div_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    LOAD,
    SETTLE
  } state_t;

  localparam int unsigned MIN_RATIO = 2;

  function automatic logic ratio_ok(
    input int unsigned r,
    input int unsigned max_r
  );
    return (r >= MIN_RATIO) && (r <= max_r);
  endfunction

  function automatic int unsigned ratio_clamp(
    input int unsigned r,
    input int unsigned max_r
  );
    if (r < MIN_RATIO) return MIN_RATIO;
    if (r > max_r) return max_r;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Ratio update handshake between register file and divider config stage.
interface clk_div_cfg_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic [WIDTH-1:0] ratio;
  logic             ready;

  modport master (
    output valid,
    output ratio,
    input  ready
  );

  modport slave (
    input  valid,
    input  ratio,
    output ready
  );

endinterface

// File: rtl/clk_div_edge_sync.sv
// Two-flop sampler of the divided clock with falling-edge detect.
module clk_div_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], din};
  end

  assign fall = sh[2] & ~sh[1];

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Divider ratio/enable/reset sequencer with glitch-safe reload.
// Define CLK_DIV_CFG_CLAMP_EN to clamp illegal ratios instead of rejecting.
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MAX_RATIO     = 255,
  parameter int DEFAULT_RATIO = 2,
  parameter int SETTLE_CYC    = 4
) (
  input  logic             I_ref_clk,
  input  logic             I_rst_n,
  clk_div_cfg_ctrl_if.slave cfg,
  input  logic             I_div_clk,
  output logic [WIDTH-1:0] O_div_ratio,
  output logic             O_clk_en,
  output logic             O_div_rst_n,
  output logic             O_busy,
  output logic             O_cfg_err
);

  localparam int TMO = 2 * MAX_RATIO + 2;
  localparam int TW  = $clog2(TMO);
  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int CW  = (TW > SW) ? TW : SW;

  localparam logic [CW-1:0]    TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0]    SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [WIDTH-1:0] DEF_R    = WIDTH'(DEFAULT_RATIO);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] staged;
  logic [WIDTH-1:0] req;
  logic             req_bad;
  logic             req_take;
  logic             fall;

  clk_div_edge_sync u_sync (
    .clk  (I_ref_clk),
    .rst_n(I_rst_n),
    .din  (I_div_clk),
    .fall (fall)
  );

  always_comb begin
    req_bad = !ratio_ok(32'(cfg.ratio), MAX_RATIO);
`ifdef CLK_DIV_CFG_CLAMP_EN
    req      = WIDTH'(ratio_clamp(32'(cfg.ratio), MAX_RATIO));
    req_take = 1'b1;
`else
    req      = cfg.ratio;
    req_take = !req_bad;
`endif
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= SETTLE;
      cnt         <= '0;
      staged      <= DEF_R;
      O_div_ratio <= DEF_R;
      O_clk_en    <= 1'b0;
      O_div_rst_n <= 1'b0;
      cfg.ready   <= 1'b0;
      O_busy      <= 1'b1;
      O_cfg_err   <= 1'b0;
    end else begin
      O_cfg_err <= 1'b0;
      unique case (state)
        RUN: begin
          if (cfg.valid && cfg.ready) begin
            O_cfg_err <= req_bad;
            // same-ratio requests are absorbed without touching the divider
            if (req_take && (req != O_div_ratio)) begin
              staged    <= req;
              state     <= DRAIN;
              cnt       <= '0;
              cfg.ready <= 1'b0;
              O_busy    <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fall || (cnt == TMO_LAST)) begin
            state       <= LOAD;
            O_div_ratio <= staged;
            O_clk_en    <= 1'b0;
            O_div_rst_n <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD: begin
          state <= SETTLE;
          cnt   <= '0;
        end
        SETTLE: begin
          if (cnt == SET_LAST) begin
            state       <= RUN;
            O_clk_en    <= 1'b1;
            O_div_rst_n <= 1'b1;
            cfg.ready   <= 1'b1;
            O_busy      <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl (WIDTH=9, MAX_RATIO=255, SETTLE_CYC=4).
module tb_clk_div_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dclk;
  logic [8:0] div_ratio;
  logic       clk_en;
  logic       div_rst_n;
  logic       busy;
  logic       cfg_err;

  int checks = 0;
  int fails  = 0;
  logic [8:0] cur;

  clk_div_cfg_ctrl_if #(.WIDTH(9)) cfg ();

  clk_div_cfg_ctrl #(
    .WIDTH        (9),
    .MAX_RATIO    (255),
    .DEFAULT_RATIO(2),
    .SETTLE_CYC   (4)
  ) dut (
    .I_ref_clk  (clk),
    .I_rst_n    (rst_n),
    .cfg        (cfg),
    .I_div_clk  (dclk),
    .O_div_ratio(div_ratio),
    .O_clk_en   (clk_en),
    .O_div_rst_n(div_rst_n),
    .O_busy     (busy),
    .O_cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en,
                         input logic drst, input logic rdy,
                         input logic bsy, input logic [8:0] rat);
    chk({tag, ".clk_en"}, 32'(clk_en), 32'(en));
    chk({tag, ".div_rst_n"}, 32'(div_rst_n), 32'(drst));
    chk({tag, ".ready"}, 32'(cfg.ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".ratio"}, 32'(div_ratio), 32'(rat));
  endtask

  // full reload with a controlled falling edge two cycles after accept
  task automatic update(input logic [8:0] r, input logic [8:0] nr,
                        input logic e);
    dclk = 1'b1;
    repeat (3) tick();
    cfg.valid = 1'b1;
    cfg.ratio = r;
    tick();
    chk("upd_acc.err", 32'(cfg_err), 32'(e));
    chk_out("upd_acc", 1, 1, 0, 1, cur);
    cfg.valid = 1'b0;
    dclk = 1'b0;
    tick();
    tick();
    chk_out("upd_drain", 1, 1, 0, 1, cur);
    tick();
    chk_out("upd_load", 0, 0, 0, 1, nr);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("upd_settle", 0, 0, 0, 1, nr);
    end
    tick();
    chk_out("upd_run", 1, 1, 1, 0, nr);
    cur = nr;
  endtask

  task automatic illegal_same(input logic [8:0] r);
    cfg.valid = 1'b1;
    cfg.ratio = r;
    tick();
    chk("ill.err", 32'(cfg_err), 32'd1);
    chk_out("ill", 1, 1, 1, 0, cur);
    cfg.valid = 1'b0;
    tick();
    chk("ill.err_clr", 32'(cfg_err), 32'd0);
    chk_out("ill_after", 1, 1, 1, 0, cur);
  endtask

  initial begin
    rst_n     = 1'b0;
    dclk      = 1'b0;
    cfg.valid = 1'b0;
    cfg.ratio = '0;
    cur       = 9'd2;
    @(negedge clk);
    @(negedge clk);
    chk_out("rst", 0, 0, 0, 1, 2);
    chk("rst.err", 32'(cfg_err), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("boot_settle", 0, 0, 0, 1, 2);
    end
    tick();
    chk_out("boot_run", 1, 1, 1, 0, 2);

    cfg.valid = 1'b1;
    cfg.ratio = 9'd2;
    tick();
    chk_out("eq", 1, 1, 1, 0, 2);
    chk("eq.err", 32'(cfg_err), 32'd0);
    cfg.valid = 1'b0;
    tick();
    chk_out("eq_after", 1, 1, 1, 0, 2);

    update(9'd6, 9'd6, 1'b0);

`ifdef CLK_DIV_CFG_CLAMP_EN
    update(9'd1, 9'd2, 1'b1);
    illegal_same(9'd0);
    update(9'd300, 9'd255, 1'b1);
`else
    illegal_same(9'd1);
    illegal_same(9'd0);
    illegal_same(9'd300);
`endif

    cfg.valid = 1'b1;
    cfg.ratio = 9'd9;
    tick();
    chk_out("tmo_acc", 1, 1, 0, 1, cur);
    cfg.valid = 1'b0;
    repeat (511) tick();
    chk_out("tmo_last_drain", 1, 1, 0, 1, cur);
    tick();
    chk_out("tmo_load", 0, 0, 0, 1, 9);
    repeat (4) tick();
    chk_out("tmo_settle", 0, 0, 0, 1, 9);
    tick();
    chk_out("tmo_run", 1, 1, 1, 0, 9);
    cur = 9'd9;

    dclk = 1'b1;
    repeat (3) tick();
    cfg.valid = 1'b1;
    cfg.ratio = 9'd7;
    tick();
    cfg.valid = 1'b0;
    dclk = 1'b0;
    repeat (3) tick();
    chk_out("r7_load", 0, 0, 0, 1, 7);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 0, 0, 1, 2);
    chk("mid_rst.err", 32'(cfg_err), 32'd0);
    cfg.valid = 1'b1;
    cfg.ratio = 9'd5;
    dclk = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rb_settle", 0, 0, 0, 1, 2);
    end
    tick();
    chk_out("rb_run", 1, 1, 1, 0, 2);
    tick();
    chk_out("rb_acc", 1, 1, 0, 1, 2);
    cfg.valid = 1'b0;
    dclk = 1'b0;
    tick();
    tick();
    chk_out("rb_drain", 1, 1, 0, 1, 2);
    tick();
    chk_out("rb_load", 0, 0, 0, 1, 5);
    repeat (4) tick();
    tick();
    chk_out("rb_run2", 1, 1, 1, 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
- Configuration/sequencing stage directly upstream of the integer clock divider; owns the divider's ratio, enable and local reset.
- Accepts ratio update requests from the register file over a valid/ready handshake and validates them.
- Applies a legal ratio glitch-safely: waits for a low phase of the divided clock, holds the divider disabled and in reset while loading, then re-enables after a settle window.

Parameters:
- WIDTH, 8, width of ratio bus; matches divider WIDTH.
- MAX_RATIO, 255, largest legal ratio; must be ≤ 2**WIDTH-1.
- DEFAULT_RATIO, 2, ratio driven from reset; must be within 2..MAX_RATIO.
- SETTLE_CYC, 4, I_ref_clk cycles the divider stays disabled/reset after load; must be ≥1.

Ports:
- I_ref_clk  in  1  reference clock, same clock as the divider.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_cfg_valid  in  1  update request valid.
- I_cfg_ratio  in  WIDTH  requested division ratio.
- O_cfg_ready  out  1  block can accept a request.
- I_div_clk  in  1  divided clock fed back from the divider, sampled on I_ref_clk.
- O_div_ratio  out  WIDTH  ratio to divider.
- O_clk_en  out  1  divider enable.
- O_div_rst_n  out  1  divider local reset, active-low, registered.
- O_busy  out  1  reconfiguration in progress.
- O_cfg_err  out  1  one-cycle pulse on rejected request.

Behaviour:
- Reset values: O_div_ratio=DEFAULT_RATIO, O_clk_en=0, O_div_rst_n=0, O_cfg_ready=0, O_busy=1, O_cfg_err=0, state=SETTLE, settle counter=0.
- All outputs are registered. Nothing is combinational from inputs to outputs.
- States and transitions:
  - RUN: O_clk_en=1, O_div_rst_n=1, O_cfg_ready=1, O_busy=0.
  - DRAIN: O_cfg_ready=0, O_busy=1, O_clk_en=1.
  - LOAD: exactly 1 cycle. O_div_ratio <= staged ratio, O_clk_en=0, O_div_rst_n=0.
  - SETTLE: O_clk_en=0, O_div_rst_n=0. Counts SETTLE_CYC cycles, then goes to RUN.
- Handshake: a transfer occurs on a cycle with I_cfg_valid && O_cfg_ready. The source holds valid and ratio until accepted. Requests arriving while not in RUN wait; they are neither dropped nor errored.
- Legality: 2 ≤ I_cfg_ratio ≤ MAX_RATIO.
  - Illegal request: transfer is consumed, O_cfg_err=1 on the next cycle for 1 cycle, state stays RUN, ratio unchanged.
  - Legal request equal to current O_div_ratio: consumed, no state change, no disruption.
  - Legal request that differs: staged, next state DRAIN.
- DRAIN:
  - I_div_clk passes through a 2-flop sampler.
  - Exit to LOAD on the first cycle the sampled value is 0 after having been 1 (falling edge).
  - Timeout: exit anyway after 2*MAX_RATIO+2 cycles. The timeout counter is sized by clog2.
  - On exit, O_clk_en drops in the same registered update as entering LOAD.
- Latency, from acceptance to O_clk_en=1 with the new ratio: DRAIN time + 1 (LOAD) + SETTLE_CYC + 1.
- Reset asserted mid-operation: immediate return to reset values. Any staged ratio is discarded, and O_div_ratio returns to DEFAULT_RATIO.
- Post-reset: SETTLE for SETTLE_CYC cycles, then RUN.

Optional Feature:
- Macro: CLK_DIV_CFG_CLAMP_EN.
- Defined: illegal ratios are clamped instead of rejected (0 or 1 -> 2; >MAX_RATIO -> MAX_RATIO). The clamped value is then handled as a legal request. O_cfg_err still pulses, flagging that a clamp occurred.
- Undefined: illegal ratios are rejected as described in Behaviour.

Decomposition:
- Shared package clk_div_pkg holds:
  - state enum (RUN, DRAIN, LOAD, SETTLE);
  - MIN_RATIO=2 constant;
  - ratio-legality function.
- One natural sub-module: clk_div_edge_sync (2-flop sampler of I_div_clk plus falling-edge detect). Everything else stays in the top.

Test Plan:
- Reset release, SETTLE_CYC=4 -> O_clk_en=0 for 4 cycles, then O_clk_en=1, O_div_ratio=2, O_cfg_ready=1.
- In RUN, request ratio 6 with the divider model running -> O_busy=1. After the next I_div_clk fall: LOAD shows O_div_ratio=6 and O_div_rst_n=0 for 1+4 cycles, then RUN with O_clk_en=1.
- Request ratio 1, then 0, then 300 with WIDTH=9, MAX_RATIO=255 -> one O_cfg_err pulse each and O_div_ratio unchanged. With CLK_DIV_CFG_CLAMP_EN: ratio becomes 2, then 255, err still pulses.
- I_div_clk stuck at 0 during DRAIN -> LOAD entered after exactly 2*255+2 cycles.
- Request equal to current ratio 2 -> accepted in 1 cycle, O_clk_en stays 1, O_busy stays 0.
- Assert I_rst_n low during SETTLE of a ratio-7 update -> outputs at reset values in the same cycle, O_div_ratio=2. After release, normal startup; a second valid held during busy is accepted only on re-entry to RUN.
